ram_scan_reader: RTL and testbench

- Read-side companion to the switch-driven single-port RAM write path.
- Shares one single-port RAM between user writes and a periodic scan reader.
- The scanner steps through every address once per tick and presents the address and data for seven-segment display, which makes the single-port RAM behave as a write-port plus display read-port pair.
- Sits between the switch and RAM interface and the display decoders.

---
 rtl/ram_scan_reader.sv | 152 +++++++++++++++
 tb/tb_ram_scan_reader.sv | 252 +++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_scan_reader.sv
// ram_scan_reader: shares one single-port RAM between user writes and a
// periodic scan reader. Once per tick the scanner reads the next address
// and presents address/data for a seven-segment display. Writes always win
// the RAM bus; a read interrupted by a write is retried on the next idle cycle.
module ram_scan_reader #(
  parameter int ADDR_W   = 5,
  parameter int DATA_W   = 4,
  parameter int TICK_DIV = 50000000,
  parameter int RD_LAT   = 1
) (
  input  logic              CLOCK_50,
  input  logic              resetn,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic [ADDR_W-1:0] ram_address,
  output logic [DATA_W-1:0] ram_data,
  output logic              ram_wren,
  input  logic [DATA_W-1:0] ram_q,
  output logic [ADDR_W-1:0] scan_addr,
  output logic [DATA_W-1:0] scan_data,
  output logic              scan_valid
);

  localparam int              CNT_W     = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TICK_DIV - 1);
  localparam logic [1:0]      WAIT_INIT = 2'(RD_LAT - 1);

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RD_WAIT = 2'd1,
    ST_CAPTURE = 2'd2
  } state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  cnt_q;
  logic [CNT_W-1:0]  cnt_d;
  logic              tick_s;
  logic              capture_s;
  logic              pending_q;
  logic [1:0]        wait_q;
  logic [ADDR_W-1:0] scan_ptr_q;
  logic [ADDR_W-1:0] scan_addr_q;
  logic [DATA_W-1:0] scan_data_q;
  logic              scan_valid_q;

  // Tick generation: free-running divider, tick on its last count.
  always_comb begin
    tick_s = (cnt_q == CNT_MAX);
    if (tick_s) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // A capture completes only when the bus was not stolen by a write.
  always_comb begin
    capture_s = (state_q == ST_CAPTURE) && !wr_req;
  end

  // RAM bus mux: writes take the bus unconditionally, otherwise the scanner
  // keeps its pointer on the address lines so read latency is met.
  always_comb begin
    ram_data = wr_data;
    if (wr_req) begin
      ram_wren    = 1'b1;
      ram_address = wr_addr;
    end else begin
      ram_wren    = 1'b0;
      ram_address = scan_ptr_q;
    end
  end

  // Divider register.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Scan FSM with pending-tick flag, coherency update and display registers.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q      <= ST_IDLE;
      pending_q    <= 1'b0;
      wait_q       <= 2'd0;
      scan_ptr_q   <= '0;
      scan_addr_q  <= '0;
      scan_data_q  <= '0;
      scan_valid_q <= 1'b0;
    end else begin
      scan_valid_q <= 1'b0;

      // A new tick outranks the clear from a capture on the same edge.
      if (tick_s) begin
        pending_q <= 1'b1;
      end else if (capture_s) begin
        pending_q <= 1'b0;
      end else begin
        pending_q <= pending_q;
      end

      // Keep the displayed word in step with writes to the displayed address.
      // Never collides with a capture, which requires wr_req low.
      if (wr_req && (wr_addr == scan_addr_q)) begin
        scan_data_q <= wr_data;
      end

      case (state_q)
        ST_IDLE: begin
          if (pending_q && !wr_req) begin
            state_q <= ST_RD_WAIT;
            wait_q  <= WAIT_INIT;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        ST_RD_WAIT: begin
          if (wr_req) begin
            state_q <= ST_IDLE;
          end else if (wait_q == 2'd0) begin
            state_q <= ST_CAPTURE;
          end else begin
            wait_q <= wait_q - 2'd1;
          end
        end
        ST_CAPTURE: begin
          if (wr_req) begin
            state_q <= ST_IDLE;
          end else begin
            scan_data_q  <= ram_q;
            scan_addr_q  <= scan_ptr_q;
            scan_valid_q <= 1'b1;
            scan_ptr_q   <= scan_ptr_q + ADDR_W'(1);
            state_q      <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  assign scan_addr  = scan_addr_q;
  assign scan_data  = scan_data_q;
  assign scan_valid = scan_valid_q;

endmodule

// File: tb/tb_ram_scan_reader.sv
// Directed bench for ram_scan_reader. Instance A uses RD_LAT=1, instance B
// RD_LAT=2; both TICK_DIV=4 with a RAM model preloaded with mem[i]=i[3:0].
// Cycle 0 is the cycle right after reset release; edge eN ends cycle N-1.
module tb_ram_scan_reader;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic resetn = 1'b1;

  logic       a_wr_req = 1'b0, a_ram_wren, a_scan_valid, a_init = 1'b0;
  logic [4:0] a_wr_addr = 5'd0, a_ram_address, a_scan_addr;
  logic [3:0] a_wr_data = 4'd0, a_ram_data, a_ram_q, a_scan_data;
  logic [3:0] a_mem [0:31];

  logic       b_wr_req = 1'b0, b_ram_wren, b_scan_valid, b_init = 1'b0;
  logic [4:0] b_wr_addr = 5'd0, b_ram_address, b_scan_addr;
  logic [3:0] b_wr_data = 4'd0, b_ram_data, b_ram_q, b_q1, b_scan_data;
  logic [3:0] b_mem [0:31];

  int n_cmp = 0;
  int n_bad = 0;

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4), .RD_LAT(1)) u_dut_a (
    .CLOCK_50(clk), .resetn(resetn), .wr_req(a_wr_req), .wr_addr(a_wr_addr),
    .wr_data(a_wr_data), .ram_address(a_ram_address), .ram_data(a_ram_data),
    .ram_wren(a_ram_wren), .ram_q(a_ram_q), .scan_addr(a_scan_addr),
    .scan_data(a_scan_data), .scan_valid(a_scan_valid)
  );

  ram_scan_reader #(.ADDR_W(5), .DATA_W(4), .TICK_DIV(4), .RD_LAT(2)) u_dut_b (
    .CLOCK_50(clk), .resetn(resetn), .wr_req(b_wr_req), .wr_addr(b_wr_addr),
    .wr_data(b_wr_data), .ram_address(b_ram_address), .ram_data(b_ram_data),
    .ram_wren(b_ram_wren), .ram_q(b_ram_q), .scan_addr(b_scan_addr),
    .scan_data(b_scan_data), .scan_valid(b_scan_valid)
  );

  // RAM model A: one-cycle registered read.
  always @(posedge clk) begin
    if (a_init) begin
      for (int i = 0; i < 32; i++) a_mem[i] <= 4'(i);
    end else if (a_ram_wren) begin
      a_mem[a_ram_address] <= a_ram_data;
    end
    a_ram_q <= a_mem[a_ram_address];
  end

  // RAM model B: two-cycle registered read.
  always @(posedge clk) begin
    if (b_init) begin
      for (int i = 0; i < 32; i++) b_mem[i] <= 4'(i);
    end else if (b_ram_wren) begin
      b_mem[b_ram_address] <= b_ram_data;
    end
    b_q1    <= b_mem[b_ram_address];
    b_ram_q <= b_q1;
  end

  task automatic do_reset();
    resetn = 1'b0; a_wr_req = 1'b0; b_wr_req = 1'b0; a_init = 1'b1; b_init = 1'b1;
    repeat (2) @(posedge clk);
    #1; a_init = 1'b0; b_init = 1'b0; resetn = 1'b1;
  endtask

  task automatic test_reset();
    #1; resetn = 1'b0; a_init = 1'b1; b_init = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({a_scan_valid, a_scan_addr, a_scan_data} !== 10'd0) begin
      n_bad++; $display("FAIL reset_outputs: got %b exp %b", {a_scan_valid, a_scan_addr, a_scan_data}, 10'd0);
    end
    n_cmp++;
    if ({a_ram_wren, a_ram_address} !== 6'd0) begin
      n_bad++; $display("FAIL reset_bus: got %b exp %b", {a_ram_wren, a_ram_address}, 6'd0);
    end
    @(posedge clk); #1; a_init = 1'b0; b_init = 1'b0; resetn = 1'b1;
    for (int e = 1; e <= 6; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (a_scan_valid !== 1'b0) begin
        n_bad++; $display("FAIL first_latency_early e%0d: got %b exp 0", e, a_scan_valid);
      end
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({a_scan_valid, a_scan_addr, a_scan_data} !== {1'b1, 5'd0, 4'd0}) begin
      n_bad++; $display("FAIL first_capture: got %b exp %b", {a_scan_valid, a_scan_addr, a_scan_data}, {1'b1, 5'd0, 4'd0});
    end
    @(posedge clk); #1;
    n_cmp++;
    if ({a_scan_valid, a_ram_address} !== {1'b0, 5'd1}) begin
      n_bad++; $display("FAIL pulse_width_ptr: got %b exp %b", {a_scan_valid, a_ram_address}, {1'b0, 5'd1});
    end
    repeat (3) begin @(posedge clk); #1; end
    n_cmp++;
    if ({a_scan_valid, a_scan_addr, a_scan_data} !== {1'b1, 5'd1, 4'd1}) begin
      n_bad++; $display("FAIL second_capture: got %b exp %b", {a_scan_valid, a_scan_addr, a_scan_data}, {1'b1, 5'd1, 4'd1});
    end
  endtask

  task automatic test_wrap();
    int cyc;
    do_reset();
    for (int k = 0; k <= 32; k++) begin
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!a_scan_valid && cyc < 8);
      n_cmp++;
      if (a_scan_valid !== 1'b1) begin
        n_bad++; $display("FAIL wrap_timeout k=%0d: got no scan_valid within %0d cycles", k, cyc);
      end else if ({a_scan_addr, a_scan_data} !== {5'(k), 4'(k)} || cyc != ((k == 0) ? 7 : 4)) begin
        n_bad++; $display("FAIL wrap_step k=%0d: got addr %0d data %0d gap %0d exp addr %0d data %0d gap %0d",
                          k, a_scan_addr, a_scan_data, cyc, 5'(k), 4'(k), (k == 0) ? 7 : 4);
      end
    end
  endtask

  task automatic test_priority();
    int cyc;
    logic [3:0] exp_d;
    do_reset();
    a_wr_addr = 5'd3; a_wr_data = 4'hF; a_wr_req = 1'b1;
    for (int c = 0; c < 12; c++) begin
      #1;
      n_cmp++;
      if ({a_ram_wren, a_ram_address, a_ram_data} !== {1'b1, 5'd3, 4'hF}) begin
        n_bad++; $display("FAIL prio_bus c%0d: got %b exp %b", c, {a_ram_wren, a_ram_address, a_ram_data}, {1'b1, 5'd3, 4'hF});
      end
      @(posedge clk); #1;
      n_cmp++;
      if (a_scan_valid !== 1'b0) begin
        n_bad++; $display("FAIL prio_no_capture c%0d: got %b exp 0", c, a_scan_valid);
      end
    end
    a_wr_req = 1'b0; #1;
    n_cmp++;
    if ({a_ram_wren, a_ram_address} !== {1'b0, 5'd0}) begin
      n_bad++; $display("FAIL prio_release_bus: got %b exp %b", {a_ram_wren, a_ram_address}, {1'b0, 5'd0});
    end
    for (int e = 13; e <= 18; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (a_scan_valid !== (e == 15)) begin
        n_bad++; $display("FAIL prio_deferred e%0d: got %b exp %b", e, a_scan_valid, (e == 15));
      end
      if (e == 15) begin
        n_cmp++;
        if ({a_scan_addr, a_scan_data} !== {5'd0, 4'd0}) begin
          n_bad++; $display("FAIL prio_deferred_data: got %b exp %b", {a_scan_addr, a_scan_data}, 9'd0);
        end
      end
    end
    for (int k = 1; k <= 3; k++) begin
      exp_d = (k == 3) ? 4'hF : 4'(k);
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!a_scan_valid && cyc < 8);
      n_cmp++;
      if ({a_scan_valid, a_scan_addr, a_scan_data} !== {1'b1, 5'(k), exp_d}) begin
        n_bad++; $display("FAIL prio_after k=%0d: got valid %b addr %0d data %h exp 1 %0d %h",
                          k, a_scan_valid, a_scan_addr, a_scan_data, k, exp_d);
      end
    end
  endtask

  task automatic test_abort();
    do_reset();
    for (int e = 1; e <= 5; e++) begin @(posedge clk); #1; end
    // Cycle 5: instance B is in RD_WAIT; steal the bus to write 0xA at the scan address.
    b_wr_addr = 5'd0; b_wr_data = 4'hA; b_wr_req = 1'b1;
    @(posedge clk); #1; b_wr_req = 1'b0;
    n_cmp++;
    if ({b_scan_valid, b_scan_data} !== {1'b0, 4'hA}) begin
      n_bad++; $display("FAIL abort_coherent: got %b exp %b", {b_scan_valid, b_scan_data}, {1'b0, 4'hA});
    end
    for (int e = 7; e <= 16; e++) begin
      @(posedge clk); #1;
      n_cmp++;
      if (b_scan_valid !== (e == 10 || e == 16)) begin
        n_bad++; $display("FAIL abort_valid e%0d: got %b exp %b", e, b_scan_valid, (e == 10 || e == 16));
      end
      if (e == 10 || e == 16) begin
        n_cmp++;
        if ({b_scan_addr, b_scan_data} !== ((e == 10) ? {5'd0, 4'hA} : {5'd1, 4'd1})) begin
          n_bad++; $display("FAIL abort_retry e%0d: got %b exp %b", e, {b_scan_addr, b_scan_data},
                            (e == 10) ? {5'd0, 4'hA} : {5'd1, 4'd1});
        end
      end
    end
  endtask

  task automatic test_coherency();
    int cyc;
    do_reset();
    for (int k = 0; k <= 5; k++) begin
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!a_scan_valid && cyc < 8);
    end
    n_cmp++;
    if ({a_scan_valid, a_scan_addr} !== {1'b1, 5'd5}) begin
      n_bad++; $display("FAIL coh_setup: got %b exp %b", {a_scan_valid, a_scan_addr}, {1'b1, 5'd5});
    end
    a_wr_addr = 5'd5; a_wr_data = 4'h7; a_wr_req = 1'b1;
    @(posedge clk); #1;
    n_cmp++;
    if ({a_scan_valid, a_scan_addr, a_scan_data} !== {1'b0, 5'd5, 4'h7}) begin
      n_bad++; $display("FAIL coh_update: got %b exp %b", {a_scan_valid, a_scan_addr, a_scan_data}, {1'b0, 5'd5, 4'h7});
    end
    a_wr_addr = 5'd6; a_wr_data = 4'h0;
    @(posedge clk); #1;
    n_cmp++;
    if (a_scan_data !== 4'h7) begin
      n_bad++; $display("FAIL coh_other_addr: got %h exp %h", a_scan_data, 4'h7);
    end
    a_wr_req = 1'b0;
  endtask

  task automatic test_async_reset();
    int cyc;
    do_reset();
    for (int k = 0; k <= 2; k++) begin
      cyc = 0;
      do begin @(posedge clk); #1; cyc++; end while (!a_scan_valid && cyc < 8);
    end
    // Now just after e15; two more edges put instance A in RD_WAIT for addr 3.
    repeat (2) begin @(posedge clk); #1; end
    #2; resetn = 1'b0; #1;
    n_cmp++;
    if ({a_scan_valid, a_scan_addr, a_scan_data, a_ram_wren} !== 11'd0) begin
      n_bad++; $display("FAIL async_reset: got %b exp %b", {a_scan_valid, a_scan_addr, a_scan_data, a_ram_wren}, 11'd0);
    end
    repeat (2) @(posedge clk);
    #1; resetn = 1'b1;
    cyc = 0;
    do begin @(posedge clk); #1; cyc++; end while (!a_scan_valid && cyc < 10);
    n_cmp++;
    if ({a_scan_valid, a_scan_addr} !== {1'b1, 5'd0} || cyc != 7) begin
      n_bad++; $display("FAIL async_restart: got valid %b addr %0d after %0d cycles exp 1 0 after 7",
                        a_scan_valid, a_scan_addr, cyc);
    end
  endtask

  initial begin
    test_reset();
    test_wrap();
    test_priority();
    test_abort();
    test_coherency();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
